// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - MDOp codes, FSM state types and latency defaults for the mdu
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } mdop_e;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_e;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_MUL,
    CLS_DIV,
    CLS_MOVE
  } op_class_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  // Two's-complement negate when neg is set; used for magnitude/sign fixup in division.
  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle multiply/divide unit with HI/LO; MDU_MADD_EN adds madd/maddu/msub/msubu
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);

  state_e           state_q;
  mdop_e            op_q;
  logic             busy_q;
  logic             dz_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      hi_q, lo_q;
  logic [63:0]      res_q;

  mdop_e            op_d;
  op_class_e        cls_d;
  logic [63:0]      res_d;
  logic             dz_d;

  logic [63:0]      prod_s, prod_u;
  logic             sgn_div, a_neg, b_neg;
  logic [31:0]      a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

  // Decode the request and compute the result that will be committed at completion.
  always_comb begin
    prod_s  = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u  = {32'd0, A} * {32'd0, B};
    sgn_div = (MDOp == OP_DIV);
    a_neg   = sgn_div & A[31];
    b_neg   = sgn_div & B[31];
    a_mag   = cond_neg32(A, a_neg);
    b_mag   = cond_neg32(B, b_neg);
    // A zero divisor is replaced so the divider never sees 0; its result is discarded anyway.
    b_safe  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / b_safe;
    r_mag   = a_mag % b_safe;
    quo     = cond_neg32(q_mag, a_neg ^ b_neg);
    rem     = cond_neg32(r_mag, a_neg);

    cls_d = CLS_NONE;
    res_d = '0;
    dz_d  = 1'b0;
    case (mdop_e'(MDOp))
      OP_MULT:  begin cls_d = CLS_MUL; res_d = prod_s; end
      OP_MULTU: begin cls_d = CLS_MUL; res_d = prod_u; end
      OP_DIV, OP_DIVU: begin
        cls_d = CLS_DIV;
        res_d = {rem, quo};
        dz_d  = (B == 32'd0);
      end
      OP_MTHI, OP_MTLO: cls_d = CLS_MOVE;
`ifdef MDU_MADD_EN
      OP_MADD:  begin cls_d = CLS_MUL; res_d = {hi_q, lo_q} + prod_s; end
      OP_MADDU: begin cls_d = CLS_MUL; res_d = {hi_q, lo_q} + prod_u; end
      OP_MSUB:  begin cls_d = CLS_MUL; res_d = {hi_q, lo_q} - prod_s; end
      OP_MSUBU: begin cls_d = CLS_MUL; res_d = {hi_q, lo_q} - prod_u; end
`endif
      default: ;
    endcase
    op_d = (cls_d == CLS_NONE) ? OP_NONE : mdop_e'(MDOp);
  end

  // Control FSM: accept in IDLE, count down in BUSY, commit HI/LO on the final edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NONE;
      busy_q  <= 1'b0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            case (cls_d)
              CLS_MUL: begin
                state_q <= ST_BUSY;
                busy_q  <= 1'b1;
                op_q    <= op_d;
                res_q   <= res_d;
                dz_q    <= 1'b0;
                cnt_q   <= CNT_W'(MULT_CYCLES);
              end
              CLS_DIV: begin
                state_q <= ST_BUSY;
                busy_q  <= 1'b1;
                op_q    <= op_d;
                res_q   <= res_d;
                dz_q    <= dz_d;
                cnt_q   <= CNT_W'(DIV_CYCLES);
              end
              CLS_MOVE: begin
                if (op_d == OP_MTHI) hi_q <= A;
                else                 lo_q <= A;
              end
              default: ;
            endcase
          end
        end
        ST_BUSY: begin
          if (cnt_q <= CNT_W'(1)) begin
            if (op_q != OP_NONE && !dz_q) begin
              hi_q <= res_q[63:32];
              lo_q <= res_q[31:0];
            end
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            op_q    <= OP_NONE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - scoreboard bench for mdu; define MDU_MADD_EN to exercise accumulate ops
module tb_mdu;

  localparam logic [3:0] C_NONE = 4'd0, C_MULT = 4'd1, C_MULTU = 4'd2, C_DIV = 4'd3,
                         C_DIVU = 4'd4, C_MTHI = 4'd5, C_MTLO = 4'd6, C_MADD = 4'd7,
                         C_MADDU = 4'd8, C_MSUB = 4'd9, C_MSUBU = 4'd10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  MDOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI, LO;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDOp(MDOp),
    .Start(Start), .Busy(Busy), .HI(HI), .LO(LO)
  );

  // All tasks are entered and left at a falling edge.
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; MDOp = op; A = a; B = b;
    @(negedge clk);
    Start = 1'b0; MDOp = C_NONE; A = '0; B = '0;
  endtask

  task automatic push(input string name, input logic [31:0] hi, input logic [31:0] lo, input int cycles);
    exp_t e;
    e.name = name; e.hi = hi; e.lo = lo; e.cycles = cycles;
    sb.push_back(e);
  endtask

  task automatic complete();
    exp_t e;
    int n;
    logic stable;
    logic [31:0] hi0, lo0;
    e = sb.pop_front();
    n = 0; stable = 1'b1; hi0 = HI; lo0 = LO;
    while (Busy === 1'b1 && n < 200) begin
      n++;
      if (HI !== hi0 || LO !== lo0) stable = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (n !== e.cycles) begin
      failures++; $display("FAIL %s busy_cycles: got %0d exp %0d", e.name, n, e.cycles);
    end
    checks++;
    if (!stable) begin
      failures++; $display("FAIL %s hilo_stable: HI/LO changed during busy window (got 0 exp 1)", e.name);
    end
    checks++;
    if (HI !== e.hi || LO !== e.lo) begin
      failures++; $display("FAIL %s result: got HI=%h LO=%h exp HI=%h LO=%h", e.name, HI, LO, e.hi, e.lo);
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, input int cycles);
    push(name, hi, lo, cycles);
    drive(op, a, b);
    complete();
  endtask

  task automatic load_hilo(input logic [31:0] h, input logic [31:0] l);
    drive(C_MTHI, h, 32'd0);
    drive(C_MTLO, l, 32'd0);
  endtask

  task automatic test_reset();
    reset = 1'b1; Start = 1'b0; MDOp = C_NONE; A = '0; B = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      failures++; $display("FAIL reset_state: got Busy=%b HI=%h LO=%h exp 0 0 0", Busy, HI, LO);
    end
  endtask

  task automatic test_move();
    drive(C_MTHI, 32'hA5A5_1234, 32'd0);
    checks++;
    if (HI !== 32'hA5A5_1234 || Busy !== 1'b0) begin
      failures++; $display("FAIL mthi: got HI=%h Busy=%b exp HI=a5a51234 Busy=0", HI, Busy);
    end
    drive(C_MTLO, 32'h5A5A_9876, 32'd0);
    checks++;
    if (LO !== 32'h5A5A_9876 || HI !== 32'hA5A5_1234 || Busy !== 1'b0) begin
      failures++; $display("FAIL mtlo: got HI=%h LO=%h Busy=%b exp a5a51234 5a5a9876 0", HI, LO, Busy);
    end
  endtask

  task automatic test_mult();
    longint          ps;
    longint unsigned pu;
    logic [31:0]     a, b;
    run_op("mult_neg1x2", C_MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
    run_op("multu_maxx2", C_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5);
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom;
      ps = longint'($signed(a)) * longint'($signed(b));
      pu = longint'({32'd0, a}) * longint'({32'd0, b});
      run_op("mult_rand", C_MULT, a, b, ps[63:32], ps[31:0], 5);
      run_op("multu_rand", C_MULTU, a, b, pu[63:32], pu[31:0], 5);
    end
  endtask

  task automatic test_div();
    int          sa, sb_v, q, r;
    logic [31:0] qv, rv;
    run_op("div_m7_2", C_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    run_op("divu_7_2", C_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 10);
    run_op("div_7_m2", C_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10);
    run_op("div_ovf", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10);
    run_op("divu_big", C_DIVU, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 10);
    for (int i = 0; i < 3; i++) begin
      sa   = $signed($urandom_range(32'h7FFF_FFFF, 0)) - 32'sd1000000;
      sb_v = int'($urandom_range(5000, 1));
      if (i == 1) sb_v = -sb_v;
      if (i == 2) sa = -sa;
      q = sa / sb_v; r = sa % sb_v;
      qv = q; rv = r;
      run_op("div_rand", C_DIV, sa, sb_v, rv, qv, 10);
    end
  endtask

  task automatic test_div_zero();
    load_hilo(32'h11, 32'h22);
    run_op("div_by0", C_DIV, 32'd123, 32'd0, 32'h11, 32'h22, 10);
    run_op("divu_by0", C_DIVU, 32'hFFFF_FFFF, 32'd0, 32'h11, 32'h22, 10);
  endtask

  task automatic test_ignored_start();
    load_hilo(32'h11, 32'h22);
    push("mult_with_ignored", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4);
    drive(C_MULT, 32'hFFFF_FFFF, 32'd2);
    drive(C_MTLO, 32'd5, 32'd0);
    checks++;
    if (LO !== 32'h22 || HI !== 32'h11 || Busy !== 1'b1) begin
      failures++; $display("FAIL ignored_mtlo: got HI=%h LO=%h Busy=%b exp 11 22 1", HI, LO, Busy);
    end
    complete();
  endtask

  task automatic test_reset_abort();
    load_hilo(32'h33, 32'h44);
    drive(C_DIV, 32'd100, 32'd3);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      failures++; $display("FAIL reset_abort: got Busy=%b HI=%h LO=%h exp 0 0 0", Busy, HI, LO);
    end
    run_op("after_reset", C_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 5);
    reset = 1'b1; Start = 1'b1; MDOp = C_MTHI; A = 32'hDEAD;
    @(negedge clk);
    reset = 1'b0; Start = 1'b0; MDOp = C_NONE; A = '0;
    checks++;
    if (HI !== 32'd0 || Busy !== 1'b0) begin
      failures++; $display("FAIL reset_priority: got HI=%h Busy=%b exp 0 0", HI, Busy);
    end
  endtask

  task automatic test_back_to_back();
    run_op("b2b_mult", C_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 5);
    run_op("b2b_divu", C_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 10);
    run_op("b2b_multu", C_MULTU, 32'h8000_0000, 32'd4, 32'd2, 32'd0, 5);
  endtask

  task automatic test_none_codes();
`ifdef MDU_MADD_EN
    logic [3:0] codes [3] = '{C_NONE, 4'd11, 4'd15};
`else
    logic [3:0] codes [7] = '{C_NONE, C_MADD, C_MADDU, C_MSUB, C_MSUBU, 4'd11, 4'd15};
`endif
    load_hilo(32'h55, 32'h66);
    foreach (codes[i]) begin
      drive(codes[i], 32'h1234, 32'h5678);
      checks++;
      if (Busy !== 1'b0 || HI !== 32'h55 || LO !== 32'h66) begin
        failures++;
        $display("FAIL none_code_%0d: got Busy=%b HI=%h LO=%h exp 0 55 66", codes[i], Busy, HI, LO);
      end
    end
  endtask

`ifdef MDU_MADD_EN
  task automatic test_madd();
    load_hilo(32'd0, 32'hFFFF_FFFF);
    run_op("madd_carry", C_MADD, 32'd1, 32'd1, 32'd1, 32'd0, 5);
    run_op("msub_borrow", C_MSUB, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 5);
    run_op("madd_neg", C_MADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFE, 5);
    run_op("maddu", C_MADDU, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'hFFFF_FFFC, 5);
    run_op("msubu", C_MSUBU, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFE, 5);
  endtask
`endif

  initial begin
    test_reset();
    test_move();
    test_mult();
    test_div();
    test_div_zero();
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    test_none_codes();
`ifdef MDU_MADD_EN
    test_madd();
`endif
    checks++;
    if (sb.size() !== 0) begin
      failures++; $display("FAIL scoreboard_drain: got %0d entries exp 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
